// File: rtl/image_resize_nearest_ctrl_pkg.sv
// Shared widths, step type and FSM states for the nearest-neighbour resize controller.
package resize_pkg;

    localparam int ADDR_W = 11;
    localparam int FRAC_W = 16;
    localparam int DATA_W = 24;

    typedef logic [ADDR_W+FRAC_W-1:0] step_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DECIDE,
        RELEASE
    } state_t;

endpackage

// File: rtl/image_resize_nearest_ctrl_tagger.sv
// Output register stage: re-times line buffer read data and tags line/frame boundaries.
module resize_out_tagger #(
    parameter int ADDR_W = resize_pkg::ADDR_W,
    parameter int DATA_W = resize_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] dst_width,
    input  logic [ADDR_W-1:0] dst_height,
    input  logic              lb_valid,
    input  logic [DATA_W-1:0] lb_data,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              sol_o,
    output logic              eol_o,
    output logic              eof_o
);
    import resize_pkg::*;

    logic [ADDR_W-1:0] out_x;
    logic [ADDR_W-1:0] out_y;
    logic              last_x;
    logic              last_y;

    assign last_x = (out_x == dst_width - 1'b1);
    assign last_y = (out_y == dst_height - 1'b1);

    // Counters follow the pixels actually returned, so markers stay aligned with data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            sol_o   <= 1'b0;
            eol_o   <= 1'b0;
            eof_o   <= 1'b0;
            out_x   <= '0;
            out_y   <= '0;
        end else begin
            valid_o <= lb_valid;
            data_o  <= lb_data;
            sol_o   <= lb_valid && (out_x == '0);
            eol_o   <= lb_valid && last_x;
            eof_o   <= lb_valid && last_x && last_y;
            if (lb_valid) begin
                if (last_x) begin
                    out_x <= '0;
                    out_y <= last_y ? '0 : out_y + 1'b1;
                end else begin
                    out_x <= out_x + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/image_resize_nearest_ctrl.sv
// Nearest-neighbour scaler: walks source lines from the line buffer with Q11.16 step
// accumulators, repeating or releasing rows, and streams the scaled pixels out.
module image_resize_nearest_ctrl #(
    parameter int ADDR_W = resize_pkg::ADDR_W,
    parameter int FRAC_W = resize_pkg::FRAC_W,
    parameter int DATA_W = resize_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        src_width,
    input  logic [ADDR_W-1:0]        src_height,
    input  logic [ADDR_W-1:0]        dst_width,
    input  logic [ADDR_W-1:0]        dst_height,
    input  logic [ADDR_W+FRAC_W-1:0] h_step,
    input  logic [ADDR_W+FRAC_W-1:0] v_step,
    input  logic                     lb_rd_ready,
    output logic                     lb_rd_en,
    output logic [ADDR_W-1:0]        lb_rd_addr,
    output logic                     lb_rd_finish,
    input  logic                     lb_valid,
    input  logic [DATA_W-1:0]        lb_data,
    output logic                     valid_o,
    output logic [DATA_W-1:0]        data_o,
    output logic                     sol_o,
    output logic                     eol_o,
    output logic                     eof_o
);
    import resize_pkg::*;

    localparam int ACC_W = ADDR_W + FRAC_W;

    state_t            state;
    logic              cfg_pending;
    logic              cfg_load;
    logic [ADDR_W-1:0] src_w_q;
    logic [ADDR_W-1:0] src_h_q;
    logic [ADDR_W-1:0] dst_w_q;
    logic [ADDR_W-1:0] dst_h_q;
    logic [ACC_W-1:0]  h_step_q;
    logic [ACC_W-1:0]  v_step_q;

    logic [ADDR_W-1:0] src_row;
    logic [ADDR_W-1:0] dst_row;
    logic [ADDR_W-1:0] x_cnt;
    logic [ACC_W-1:0]  v_acc;
    logic [ACC_W-1:0]  h_acc;

    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] h_idx;
    logic [ADDR_W-1:0] src_w_max;
    logic [ADDR_W-1:0] rd_idx;
    logic              row_wanted;
    logic              src_last;
    logic              last_read;

    assign tgt        = v_acc[ACC_W-1:FRAC_W];
    assign h_idx      = h_acc[ACC_W-1:FRAC_W];
    assign src_w_max  = src_w_q - 1'b1;
    assign rd_idx     = (h_idx > src_w_max) ? src_w_max : h_idx;
    assign row_wanted = (dst_row < dst_h_q) && (dst_w_q != '0) && (tgt == src_row);
    assign src_last   = (src_row == src_h_q - 1'b1);
    assign last_read  = (x_cnt == dst_w_q);

    // Config is sampled once after reset and again only on the frame-wrap release.
    assign cfg_load = ((state == IDLE) && cfg_pending) || ((state == RELEASE) && src_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_w_q  <= '0;
            src_h_q  <= '0;
            dst_w_q  <= '0;
            dst_h_q  <= '0;
            h_step_q <= '0;
            v_step_q <= '0;
        end else if (cfg_load) begin
            src_w_q  <= src_width;
            src_h_q  <= src_height;
            dst_w_q  <= dst_width;
            dst_h_q  <= dst_height;
            h_step_q <= h_step;
            v_step_q <= v_step;
        end
    end

    // Entering EMIT issues the x=0 read immediately, so h_acc starts one step ahead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cfg_pending  <= 1'b1;
            lb_rd_en     <= 1'b0;
            lb_rd_addr   <= '0;
            lb_rd_finish <= 1'b0;
            src_row      <= '0;
            dst_row      <= '0;
            x_cnt        <= '0;
            v_acc        <= '0;
            h_acc        <= '0;
        end else begin
            lb_rd_en     <= 1'b0;
            lb_rd_finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_pending) begin
                        cfg_pending <= 1'b0;
                    end else if (lb_rd_ready) begin
                        if (row_wanted) begin
                            state      <= EMIT;
                            lb_rd_en   <= 1'b1;
                            lb_rd_addr <= '0;
                            h_acc      <= h_step_q;
                            x_cnt      <= ADDR_W'(1);
                        end else begin
                            state        <= RELEASE;
                            lb_rd_finish <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (last_read) begin
                        dst_row <= dst_row + 1'b1;
                        v_acc   <= v_acc + v_step_q;
                        state   <= DECIDE;
                    end else begin
                        lb_rd_en   <= 1'b1;
                        lb_rd_addr <= rd_idx;
                        h_acc      <= h_acc + h_step_q;
                        x_cnt      <= x_cnt + 1'b1;
                    end
                end
                DECIDE: begin
                    if (row_wanted) begin
                        state      <= EMIT;
                        lb_rd_en   <= 1'b1;
                        lb_rd_addr <= '0;
                        h_acc      <= h_step_q;
                        x_cnt      <= ADDR_W'(1);
                    end else begin
                        state        <= RELEASE;
                        lb_rd_finish <= 1'b1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    if (src_last) begin
                        src_row <= '0;
                        dst_row <= '0;
                        v_acc   <= '0;
                    end else begin
                        src_row <= src_row + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    resize_out_tagger #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_tagger (
        .clk        (clk),
        .reset      (reset),
        .dst_width  (dst_w_q),
        .dst_height (dst_h_q),
        .lb_valid   (lb_valid),
        .lb_data    (lb_data),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .sol_o      (sol_o),
        .eol_o      (eol_o),
        .eof_o      (eof_o)
    );

endmodule

// File: tb/tb_image_resize_nearest_ctrl.sv
// Directed bench for image_resize_nearest_ctrl with a 2-cycle line buffer model whose
// read data encodes {source line, source x}.
module tb_image_resize_nearest_ctrl;

    localparam logic [26:0] ONE     = 27'h10000;
    localparam logic [26:0] HALF    = 27'h08000;
    localparam logic [26:0] TWO     = 27'h20000;
    localparam logic [26:0] ONEHALF = 27'h18000;

    typedef struct {
        string            name;
        logic [10:0]      sw;
        logic [10:0]      sh;
        logic [10:0]      dw;
        logic [10:0]      dh;
        logic [26:0]      hs;
        logic [26:0]      vs;
        int               npix;
        logic [7:0][11:0] cols;
        logic [3:0][7:0]  rows;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [10:0] src_width;
    logic [10:0] src_height;
    logic [10:0] dst_width;
    logic [10:0] dst_height;
    logic [26:0] h_step;
    logic [26:0] v_step;
    logic        lb_rd_ready;
    logic        lb_rd_en;
    logic [10:0] lb_rd_addr;
    logic        lb_rd_finish;
    logic        lb_valid;
    logic [23:0] lb_data;
    logic        valid_o;
    logic [23:0] data_o;
    logic        sol_o;
    logic        eol_o;
    logic        eof_o;

    vec_t        vecs[7];
    int          pass_cnt;
    int          total_cnt;
    int          lines_done;
    int          lines_limit;
    int          cyc;
    int          rd_cnt;
    int          fin_cnt;
    int          overlap_cnt;
    int          first_rd;
    int          first_val;
    logic [27:0] pix_q[$];
    logic        p1_v;
    logic        p2_v;
    logic [23:0] p1_d;
    logic [23:0] p2_d;

    image_resize_nearest_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .src_width    (src_width),
        .src_height   (src_height),
        .dst_width    (dst_width),
        .dst_height   (dst_height),
        .h_step       (h_step),
        .v_step       (v_step),
        .lb_rd_ready  (lb_rd_ready),
        .lb_rd_en     (lb_rd_en),
        .lb_rd_addr   (lb_rd_addr),
        .lb_rd_finish (lb_rd_finish),
        .lb_valid     (lb_valid),
        .lb_data      (lb_data),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .sol_o        (sol_o),
        .eol_o        (eol_o),
        .eof_o        (eof_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line buffer model: always holds the next line until lines_limit lines were released.
    assign lb_rd_ready = (lines_done < lines_limit);
    assign lb_valid    = p2_v;
    assign lb_data     = p2_d;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_v       <= 1'b0;
            p2_v       <= 1'b0;
            p1_d       <= '0;
            p2_d       <= '0;
            lines_done <= 0;
        end else begin
            p1_v <= lb_rd_en;
            p1_d <= {4'h0, lines_done[7:0], 1'b0, lb_rd_addr};
            p2_v <= p1_v;
            p2_d <= p1_d;
            if (lb_rd_finish) lines_done <= lines_done + 1;
        end
    end

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic sampleCycle();
        @(negedge clk);
        cyc++;
        if (valid_o) begin
            pix_q.push_back({data_o, sol_o, eol_o, eof_o});
            if (first_val < 0) first_val = cyc;
        end
        if (lb_rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (lb_rd_finish) fin_cnt++;
        if (lb_rd_en && lb_rd_finish) overlap_cnt++;
    endtask

    task automatic clearCapture();
        pix_q.delete();
        rd_cnt      = 0;
        fin_cnt     = 0;
        overlap_cnt = 0;
        first_rd    = -1;
        first_val   = -1;
    endtask

    task automatic startRun(input vec_t v, input int frames);
        src_width   = v.sw;
        src_height  = v.sh;
        dst_width   = v.dw;
        dst_height  = v.dh;
        h_step      = v.hs;
        v_step      = v.vs;
        lines_limit = int'(v.sh) * frames;
        reset = 1'b1;
        sampleCycle();
        sampleCycle();
        clearCapture();
        reset = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (lines_done < lines_limit && n < 4000) begin
            sampleCycle();
            n++;
        end
        repeat (6) sampleCycle();
        checkValue({name, " frame done"}, 64'(lines_done >= lines_limit), 64'(1));
    endtask

    task automatic applyStimulus(input vec_t v);
        startRun(v, 1);
        waitDone(v.name);
    endtask

    task automatic checkOutput(input string name, input int base, input logic [10:0] dw,
                               input logic [10:0] dh, input int npix,
                               input logic [7:0][11:0] cols, input logic [3:0][7:0] rows);
        int          x;
        int          y;
        logic [27:0] exp_p;
        logic [27:0] act_p;
        for (int i = 0; i < npix; i++) begin
            x     = i % int'(dw);
            y     = i / int'(dw);
            exp_p = {4'h0, rows[y], cols[x], x == 0, x == int'(dw) - 1,
                     (x == int'(dw) - 1) && (y == int'(dh) - 1)};
            act_p = (base + i < pix_q.size()) ? pix_q[base + i] : '1;
            checkValue($sformatf("%s pixel %0d", name, i), 64'(act_p), 64'(exp_p));
        end
    endtask

    initial begin
        vecs[0] = '{"same4x2", 11'd4, 11'd2, 11'd4, 11'd2, ONE, ONE, 8,
                    {12'd0, 12'd0, 12'd0, 12'd0, 12'd3, 12'd2, 12'd1, 12'd0},
                    {8'd0, 8'd0, 8'd1, 8'd0}};
        vecs[1] = '{"up2x", 11'd4, 11'd2, 11'd8, 11'd4, HALF, HALF, 32,
                    {12'd3, 12'd3, 12'd2, 12'd2, 12'd1, 12'd1, 12'd0, 12'd0},
                    {8'd1, 8'd1, 8'd0, 8'd0}};
        vecs[2] = '{"down2x", 11'd8, 11'd4, 11'd4, 11'd2, TWO, TWO, 8,
                    {12'd0, 12'd0, 12'd0, 12'd0, 12'd6, 12'd4, 12'd2, 12'd0},
                    {8'd0, 8'd0, 8'd2, 8'd0}};
        vecs[3] = '{"down1p5", 11'd6, 11'd3, 11'd4, 11'd2, ONEHALF, ONEHALF, 8,
                    {12'd0, 12'd0, 12'd0, 12'd0, 12'd4, 12'd3, 12'd1, 12'd0},
                    {8'd0, 8'd0, 8'd1, 8'd0}};
        vecs[4] = '{"dstw0", 11'd4, 11'd2, 11'd0, 11'd2, ONE, ONE, 0, '0, '0};
        vecs[5] = '{"dsth0", 11'd4, 11'd2, 11'd4, 11'd0, ONE, ONE, 0, '0, '0};
        vecs[6] = '{"clamp", 11'd4, 11'd1, 11'd3, 11'd1, TWO, ONE, 3,
                    {12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd3, 12'd2, 12'd0},
                    {8'd0, 8'd0, 8'd0, 8'd0}};

        pass_cnt    = 0;
        total_cnt   = 0;
        cyc         = 0;
        lines_limit = 0;
        reset       = 1'b1;
        src_width   = '0;
        src_height  = '0;
        dst_width   = '0;
        dst_height  = '0;
        h_step      = '0;
        v_step      = '0;
        clearCapture();
        sampleCycle();
        sampleCycle();
        checkValue("reset outputs",
                   64'({valid_o, sol_o, eol_o, eof_o, lb_rd_en, lb_rd_finish, lb_rd_addr, data_o}),
                   64'(0));

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkValue({vecs[i].name, " pixel count"}, 64'(pix_q.size()), 64'(vecs[i].npix));
            checkValue({vecs[i].name, " read count"}, 64'(rd_cnt), 64'(vecs[i].npix));
            checkValue({vecs[i].name, " finish count"}, 64'(fin_cnt), 64'(vecs[i].sh));
            checkValue({vecs[i].name, " finish with read"}, 64'(overlap_cnt), 64'(0));
            if (vecs[i].npix > 0)
                checkValue({vecs[i].name, " latency"}, 64'(first_val - first_rd), 64'(3));
            checkOutput(vecs[i].name, 0, vecs[i].dw, vecs[i].dh, vecs[i].npix,
                        vecs[i].cols, vecs[i].rows);
        end

        // Two frames back to back; dst_width changes during the first one.
        startRun(vecs[0], 2);
        for (int n = 0; n < 200 && rd_cnt == 0; n++) sampleCycle();
        dst_width = 11'd2;
        waitDone("b2b");
        checkValue("b2b pixel count", 64'(pix_q.size()), 64'(12));
        checkValue("b2b finish count", 64'(fin_cnt), 64'(4));
        checkValue("b2b finish with read", 64'(overlap_cnt), 64'(0));
        checkOutput("b2b frame0", 0, 11'd4, 11'd2, 8, vecs[0].cols, vecs[0].rows);
        checkOutput("b2b frame1", 8, 11'd2, 11'd2, 4,
                    {12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd1, 12'd0},
                    {8'd0, 8'd0, 8'd3, 8'd2});

        // Reset asserted between clock edges while a row is being emitted.
        startRun(vecs[1], 1);
        for (int n = 0; n < 200 && rd_cnt < 6; n++) sampleCycle();
        checkValue("pre-reset emitting", 64'({valid_o, lb_rd_en}), 64'(2'b11));
        #2;
        reset = 1'b1;
        #1;
        checkValue("async reset outputs",
                   64'({valid_o, sol_o, eol_o, eof_o, lb_rd_en, lb_rd_finish, lb_rd_addr, data_o}),
                   64'(0));
        sampleCycle();
        clearCapture();
        reset = 1'b0;
        waitDone("post-reset");
        checkValue("post-reset pixel count", 64'(pix_q.size()), 64'(32));
        checkValue("post-reset finish count", 64'(fin_cnt), 64'(2));
        checkOutput("post-reset", 0, vecs[1].dw, vecs[1].dh, 32, vecs[1].cols, vecs[1].rows);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/image_resize_nearest_ctrl.md
# image_resize_nearest_ctrl

Nearest-neighbour scaling controller that sits directly downstream of the double-buffered line buffer. It consumes completed source lines via the `rd_ready` / `rd_en` / `rd_addr` / `rd_finish` read port. For each output row it maps output coordinates to source coordinates using Q11.16 fixed-point step accumulators. It repeats source rows (upscale) or releases them unread (downscale), and emits the scaled pixel stream with line/frame markers.

## Interface
- `ADDR_W`, default 11: width of pixel/row coordinates.
- `FRAC_W`, default 16: fractional bits of scale steps.
- `DATA_W`, default 24: RGB pixel width.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high; same net as the line buffer reset.
- `src_width`, `src_height`, in, `ADDR_W` each: source image size.
- `dst_width`, `dst_height`, in, `ADDR_W` each: output image size.
- `h_step`, `v_step`, in, `ADDR_W+FRAC_W` each: unsigned Q11.16 ratio `src/dst`, computed by software.
- `lb_rd_ready`, in, 1: a complete source line is held in the line buffer.
- `lb_rd_en`, out, 1: read strobe.
- `lb_rd_addr`, out, `ADDR_W`: source x.
- `lb_rd_finish`, out, 1: one-cycle pulse that releases the current source line.
- `lb_valid`, in, 1: line buffer read data valid, 2 cycles after `lb_rd_en`.
- `lb_data`, in, `DATA_W`: line buffer read data.
- `valid_o`, out, 1: output pixel valid. There is no backpressure; the sink always accepts.
- `data_o`, out, `DATA_W`: output pixel.
- `sol_o`, `eol_o`, `eof_o`, out, 1 each: start-of-line, end-of-line, and end-of-frame markers, qualified by `valid_o`.

## Operation
- Configuration (`src_*`, `dst_*`, `*_step`) is latched at reset release and at each frame wrap. Mid-frame changes are ignored.
- State is held in `src_row`, `dst_row`, `v_acc` (Q11.16), and `h_acc` (Q11.16). Target source row is `tgt = v_acc >> FRAC_W`.
- **IDLE**
  - Wait for `lb_rd_ready`.
  - If `dst_row < dst_height` and `tgt == src_row`, go to EMIT with `h_acc = 0`.
  - Otherwise go to RELEASE.
- **EMIT**
  - One read per cycle for `dst_width` cycles: `lb_rd_en = 1`, `lb_rd_addr = min(h_acc >> FRAC_W, src_width-1)`, then `h_acc += h_step`.
  - After the last read, `dst_row += 1`, `v_acc += v_step`, go to DECIDE.
- **DECIDE** (1 cycle, `lb_rd_en = 0`)
  - If `dst_row < dst_height` and the new `tgt == src_row`, return to EMIT (row repeat, no handshake).
  - Otherwise go to RELEASE.
- **RELEASE** (1 cycle)
  - Assert `lb_rd_finish`.
  - If `src_row == src_height-1`: frame wrap. Set `src_row`, `dst_row`, `v_acc` to 0, relatch configuration, go to IDLE.
  - Otherwise `src_row += 1`, go to IDLE.
- Rows with `tgt > src_row` are released without reads (downscale skip). When `dst_row == dst_height`, all remaining source rows are drained by RELEASE so the line buffer never stalls the writer.
- If `dst_width == 0` or `dst_height == 0`: no reads and no output; every source row is released.
- Arithmetic:
  - Accumulators are `ADDR_W+FRAC_W` bits, unsigned, with floor mapping and zero start phase.
  - The `h_acc` index is clamped to `src_width-1`.
  - `v_acc` needs no clamp because drained rows are released.
- Output path:
  - `valid_o` and `data_o` are `lb_valid` and `lb_data` registered once.
  - Output counters `out_x` and `out_y` advance on `lb_valid`.
  - `sol_o` is asserted at `out_x == 0`.
  - `eol_o` is asserted at `out_x == dst_width-1`.
  - `eof_o` is asserted at `eol_o` and `out_y == dst_height-1`; `out_x` and `out_y` then wrap to 0.

## Timing
- Reset values: all outputs 0, state IDLE, all counters and accumulators 0.
- Latency: `lb_rd_en` to `valid_o` is 3 cycles (2 in the line buffer, 1 here).
- Throughput: 1 pixel/clk within a row.
- Per-row overhead is 1 cycle (DECIDE), plus 1 cycle (RELEASE) when the source row changes, plus the IDLE sample cycle.
- `lb_rd_finish` is never asserted in the same cycle as `lb_rd_en`. It is always at least 1 cycle after the last read of the row, so the line buffer's read-select flag is stable for in-flight data.
- IDLE samples `lb_rd_ready` no earlier than the cycle after `lb_rd_finish`, so buffer status has already updated.
- Reset mid-row: output stops immediately. Up to 2 in-flight line buffer reads are discarded because the line buffer shares the reset.

## Structure
- Shared package `resize_pkg` holds `ADDR_W`, `FRAC_W`, `DATA_W`, the Q11.16 step typedef, and the state enum (IDLE, EMIT, DECIDE, RELEASE).
- One sub-module, `resize_out_tagger`: the output register and `out_x`/`out_y` counters generating `sol_o`/`eol_o`/`eof_o`.
- The FSM and accumulators live in the top level.

## Test plan
- 4x2 to 4x2 (step 1.0):
  - Addresses are 0,1,2,3 per row.
  - One `lb_rd_finish` after each row.
  - 8 `valid_o` pulses, `eof_o` on the 8th.
- 4x2 to 8x4 (step 0.5):
  - Addresses are 0,0,1,1,2,2,3,3.
  - Each source row is read twice, then released.
  - 32 output pixels.
- 8x4 to 4x2 (step 2.0):
  - Addresses are 0,2,4,6.
  - Source rows 1 and 3 are released with zero reads.
  - 8 output pixels.
- 6x3 to 4x2 (step 1.5):
  - Addresses are 0,1,3,4.
  - Row 1 is used, not row 2 (floor).
  - Row 2 is drained after the last output row.
- Back-to-back frames:
  - Change `dst_width` from 4 to 2 mid-frame.
  - The new value takes effect only after the wrap RELEASE of source row `src_height-1`.
- Assert `reset` mid-EMIT:
  - All outputs are 0 within the same cycle (async).
  - After release, the first frame restarts at `src_row` 0 with correct `sol_o`.
